mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing the single RAM between the instruction-fetch side of the control unit (port 0) and a data load/store requester (port 1). Accepts one request at a time, drives the RAM request/ready handshake, returns read data and a one-cycle acknowledge to the winning port, and alternates grants under contention. Sits between the control unit / datapath and the RAM.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- TIMEOUT, 64, max cycles in BUSY before abort (used only with watchdog), ≥2
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  **reset: asynchronous, active-low**; one clock domain (clk)
- m0_req / m1_req  in  1  request level, held until ack
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_W  address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  DATA_W  registered read data, held until that port's next ack
- m0_err / m1_err  out  1  pulses with ack on watchdog abort
- ram_req  out  1  RAM access request, registered
- ram_we  out  1  RAM write enable, valid with ram_req
- ram_addr  out  ADDR_W  RAM address, valid with ram_req
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid when ram_ready=1
- ram_ready  in  1  RAM completion, sampled only in BUSY

## Operation
- States: IDLE, BUSY, ACK.
- IDLE: if any req=1, pick winner, latch its we/addr/wdata into ram_* regs, set ram_req=1, → BUSY. No req → stay, ram_req=0.
- Arbitration: one requester → it wins. Both → port ≠ last_grant wins. last_grant updates on every grant.
- BUSY: ram_req/we/addr/wdata held constant. On ram_ready=1: if read, capture ram_rdata into winner's rdata reg; drop ram_req; → ACK.
- ACK: winner's ack=1 for exactly this cycle; all req inputs ignored; → IDLE. Requester deasserts req at the edge ending ack (or keeps it to request again).
- A write ack leaves that port's rdata unchanged.
- Requests changing during BUSY/ACK ignored; only IDLE samples.
- ram_ready outside BUSY ignored.

## Timing
- Reset: state=IDLE, ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0, m*_ack=0, m*_err=0, m*_rdata=0, last_grant=1 (port 0 wins first tie), watchdog count=0. Assertion mid-transaction drops ram_req immediately; no ack issued.
- Zero-wait RAM: req sampled at edge N → ram_req high cycle N..N+1; ram_ready in cycle N+1 → ack in cycle N+2. Minimum 2 cycles sample-to-ack; +1 per RAM wait cycle.
- Back-to-back: a new request may be sampled at the edge following ack; throughput 1 access per 3 cycles at zero wait.
- Under continuous contention grants strictly alternate 0,1,0,1…

## Configuration
- MEM_ARB_WATCHDOG_EN defined: counter runs in BUSY, cleared on entry; when it reaches TIMEOUT−1 without ram_ready, ram_req drops, → ACK with winner's ack=1 and err=1, rdata unchanged. ram_ready in that same cycle takes precedence (normal completion, err=0).
- Not defined: no counter; BUSY waits indefinitely; m*_err tied 0.

## Structure
- Package mem_arb_pkg: state enum (IDLE, BUSY, ACK), port index constants PORT_FETCH=0, PORT_DATA=1, default widths.
- Sub-module arb_rr2: combinational 2-way round-robin pick (req0, req1, last_grant → grant_valid, grant_idx). Rest in mem_arbiter.

## Test plan
- Reset then m0 read addr 0x0010, RAM ready 1 cycle later with 0xBEEF → m0_ack in 3rd cycle after sample, m0_rdata=0xBEEF, m1_ack never high.
- m1 write addr 0x0200 data 0x1234, RAM 3 wait cycles → ram_we=1, ram_addr=0x0200, ram_wdata=0x1234 held 4 cycles, one m1_ack, m1_rdata unchanged.
- Both req held high 6 transactions → grant order 0,1,0,1,0,1; each ack exactly one cycle.
- rst_n low during BUSY → ram_req 0 same cycle, no ack; after release first tie goes to port 0.
- Watchdog (macro on, TIMEOUT=8), ram_ready never asserted → ack+err on port after 8 BUSY cycles, ram_req low, state IDLE next.
- ram_ready pulsed while IDLE with no req → no ack, rdata unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port RAM arbiter.
//   state_e       : arbiter FSM states (IDLE, BUSY, ACK)
//   PORT_FETCH/DATA: requester port indices (instruction fetch / load-store)
//   *_DEF         : default widths and watchdog timeout
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned TIMEOUT_DEF = 64;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// arb_rr2: combinational two-way round-robin pick.
//   req0, req1  : request levels of port 0 / port 1
//   last_grant  : port granted most recently
//   grant_valid : at least one request present
//   grant_idx   : winning port (the one that was not granted last on a tie)
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_idx
);

  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant_idx = (last_grant == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
    end else begin
      grant_idx = req1 ? PORT_DATA : PORT_FETCH;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM between instruction fetch (port 0) and
// load/store (port 1). One access at a time, round-robin on contention.
//   m*_req/we/addr/wdata : requester command, held until ack
//   m*_ack/rdata/err     : one-cycle completion, held read data, abort flag
//   ram_req/we/addr/wdata: registered RAM command, stable while BUSY
//   ram_rdata/ram_ready  : RAM response, only looked at in BUSY
// Optional macro MEM_ARB_WATCHDOG_EN: aborts a BUSY access after TIMEOUT
// cycles without ram_ready, acking the winner with err=1.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready
);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              ram_req_q, ram_req_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic              grant_valid_c;
  logic              grant_idx_c;

`ifdef MEM_ARB_WATCHDOG_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err0_q, err0_d, err1_q, err1_d;
`endif

  arb_rr2 u_rr2 (
    .req0        (m0_req),
    .req1        (m1_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid_c),
    .grant_idx   (grant_idx_c)
  );

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_DATA;  // port 0 wins the first tie
      ram_req_q    <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
`ifdef MEM_ARB_WATCHDOG_EN
      cnt_q        <= '0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ram_req_q    <= ram_req_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
`ifdef MEM_ARB_WATCHDOG_EN
      cnt_q        <= cnt_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
`endif
    end
  end

  // Next-state and output logic; last_grant_q doubles as the current winner
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ram_req_d    = ram_req_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
`ifdef MEM_ARB_WATCHDOG_EN
    cnt_d        = cnt_q;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (grant_valid_c) begin
          last_grant_d = grant_idx_c;
          ram_req_d    = 1'b1;
          ram_we_d     = (grant_idx_c == PORT_DATA) ? m1_we    : m0_we;
          ram_addr_d   = (grant_idx_c == PORT_DATA) ? m1_addr  : m0_addr;
          ram_wdata_d  = (grant_idx_c == PORT_DATA) ? m1_wdata : m0_wdata;
          state_d      = BUSY;
`ifdef MEM_ARB_WATCHDOG_EN
          cnt_d        = '0;
`endif
        end
      end

      BUSY: begin
        if (ram_ready) begin
          ram_req_d = 1'b0;
          state_d   = ACK;
          if (last_grant_q == PORT_FETCH) begin
            ack0_d = 1'b1;
            if (!ram_we_q) rdata0_d = ram_rdata;
          end else begin
            ack1_d = 1'b1;
            if (!ram_we_q) rdata1_d = ram_rdata;
          end
        end
`ifdef MEM_ARB_WATCHDOG_EN
        // Timeout only when ram_ready did not arrive in the same cycle
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          ram_req_d = 1'b0;
          state_d   = ACK;
          if (last_grant_q == PORT_FETCH) begin
            ack0_d = 1'b1;
            err0_d = 1'b1;
          end else begin
            ack1_d = 1'b1;
            err1_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign m0_ack    = ack0_q;
  assign m1_ack    = ack1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

`ifdef MEM_ARB_WATCHDOG_EN
  assign m0_err = err0_q;
  assign m1_err = err1_q;
`else
  // Without the watchdog an access waits forever and never errors
  logic [31:0] unused_timeout_c;
  assign unused_timeout_c = 32'(TIMEOUT);
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter.
// Stimulus predicts each transaction's winner and response from a
// queue/array model and pushes it; RAM-side and ack-side monitors pop/compare.
// Watchdog checks are compiled when MEM_ARB_WATCHDOG_EN is defined.
module tb_mem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m0_ack, m0_err;
  logic [DW-1:0] m0_rdata;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m1_ack, m1_err;
  logic [DW-1:0] m1_rdata;
  logic          ram_req, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          ram_ready = 1'b0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            v;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct {
    bit            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    bit            err;
  } exp_t;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t          exp_q[$];
  int            grant_log[$];
  txn_t          pend[2];
  bit            m_last;
  logic [DW-1:0] m_rdata[2];
  logic [DW-1:0] m_mem[logic [AW-1:0]];
  logic [DW-1:0] ram_mem[logic [AW-1:0]];

  int ram_wait = 0;
  bit stray    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return DW'(a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    if (m_mem.exists(a)) return m_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
    if (ram_mem.exists(a)) return ram_mem[a];
    return init_val(a);
  endfunction

  // Reference: arbitration rule + memory semantics, pushes expected response
  function automatic int predict(input bit abort);
    int   win;
    exp_t e;
    if (pend[0].v && pend[1].v) win = (m_last == 1'b1) ? 0 : 1;
    else                        win = pend[1].v ? 1 : 0;
    m_last  = 1'(win);
    e.port  = 1'(win);
    e.we    = pend[win].we;
    e.addr  = pend[win].addr;
    e.wdata = pend[win].wdata;
    e.err   = abort;
    if (abort) begin
      e.rdata = m_rdata[win];
    end else if (pend[win].we) begin
      m_mem[pend[win].addr] = pend[win].wdata;
      e.rdata = m_rdata[win];
    end else begin
      e.rdata = model_rd(pend[win].addr);
      m_rdata[win] = e.rdata;
    end
    exp_q.push_back(e);
    return win;
  endfunction

  task automatic drive();
    m0_req = pend[0].v; m0_we = pend[0].we; m0_addr = pend[0].addr; m0_wdata = pend[0].wdata;
    m1_req = pend[1].v; m1_we = pend[1].we; m1_addr = pend[1].addr; m1_wdata = pend[1].wdata;
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.v     = 1'b1;
    t.we    = 1'($urandom_range(0, 1));
    t.addr  = AW'($urandom_range(0, 7)) * 16'h0101;
    t.wdata = DW'($urandom);
    return t;
  endfunction

  // One transaction from sample edge to the edge ending ack; checks latency
  task automatic do_round(input int wait_cyc, input bit abort);
    int win;
    int lat;
    bit got;
    ram_wait = wait_cyc;
    drive();
    win = predict(abort);
    lat = 0;
    got = 1'b0;
    while (lat < 200 && !got) begin
      @(negedge clk);
      lat++;
      if (m0_ack || m1_ack) got = 1'b1;
    end
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    else      check("ack_latency", 32'(lat), abort ? 32'(3 + TO - 1) : 32'(3 + wait_cyc));
    pend[win].v = 1'b0;
    @(posedge clk);
    #1;
    drive();
  endtask

  // RAM model: ready after ram_wait BUSY cycles; checks command and its stability
  int            k = 0;
  bit            rdy;
  logic          cap_we;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;
  always @(negedge clk) begin
    rdy = 1'b0;
    if (ram_req) begin
      if (k == 0) begin
        cap_we = ram_we; cap_addr = ram_addr; cap_wdata = ram_wdata;
        if (exp_q.size() == 0) begin
          check("ram_req_unexpected", 32'd1, 32'd0);
        end else begin
          check("ram_we", 32'(ram_we), 32'(exp_q[0].we));
          check("ram_addr", 32'(ram_addr), 32'(exp_q[0].addr));
          if (exp_q[0].we) check("ram_wdata", 32'(ram_wdata), 32'(exp_q[0].wdata));
        end
      end else begin
        check("ram_hold_addr", 32'(ram_addr), 32'(cap_addr));
        check("ram_hold_we_wdata", {15'd0, ram_we, ram_wdata}, {15'd0, cap_we, cap_wdata});
      end
      rdy = (k == ram_wait);
      k++;
    end else begin
      k = 0;
    end
    ram_ready = rdy || stray;
    ram_rdata = rdy ? ram_rd(ram_addr) : DW'($urandom);
    if (rdy && ram_we) ram_mem[ram_addr] = ram_wdata;
  end

  // Ack monitor: pops the scoreboard on every ack cycle
  exp_t e_mon;
  always @(negedge clk) begin
    if (rst_n && (m0_ack || m1_ack)) begin
      check("single_ack", {30'd0, m1_ack, m0_ack}, m1_ack ? 32'd2 : 32'd1);
      if (exp_q.size() == 0) begin
        check("ack_unexpected", 32'd1, 32'd0);
      end else begin
        e_mon = exp_q.pop_front();
        grant_log.push_back(m1_ack ? 1 : 0);
        check("ack_port", 32'(m1_ack), 32'(e_mon.port));
        check("rdata", e_mon.port ? 32'(m1_rdata) : 32'(m0_rdata), 32'(e_mon.rdata));
        check("err", {30'd0, m1_err, m0_err},
              e_mon.err ? (e_mon.port ? 32'd2 : 32'd1) : 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    m_last     = 1'b1;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    pend[0]    = '{1'b0, 1'b0, '0, '0};
    pend[1]    = '{1'b0, 1'b0, '0, '0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ram_req", 32'(ram_req), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_ack_err", {28'd0, m0_ack, m1_ack, m0_err, m1_err}, 32'd0);
    check("rst_rdata", {m0_rdata, m1_rdata}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fetch read, zero-wait RAM
    ram_mem[16'h0010] = 16'hBEEF;
    m_mem[16'h0010]   = 16'hBEEF;
    pend[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000};
    do_round(0, 1'b0);
    check("fetch_rdata_beef", 32'(m0_rdata), 32'h0000BEEF);

    // Data write, 3 wait cycles; rdata must stay put
    pend[1] = '{1'b1, 1'b1, 16'h0200, 16'h1234};
    do_round(3, 1'b0);
    check("write_mem", 32'(ram_rd(16'h0200)), 32'h00001234);

    // Stray ram_ready while idle
    stray = 1'b1;
    repeat (2) @(negedge clk);
    stray = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("stray_no_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
    end
    check("stray_rdata", {m0_rdata, m1_rdata}, {m_rdata[0], m_rdata[1]});
    @(posedge clk);
    #1;

    // Ready on the last allowed BUSY cycle completes normally
    pend[0] = '{1'b1, 1'b0, 16'h0404, 16'h0000};
    do_round(TO - 1, 1'b0);

`ifdef MEM_ARB_WATCHDOG_EN
    // RAM never answers: abort with err, rdata unchanged
    pend[1] = '{1'b1, 1'b0, 16'h0505, 16'h0000};
    do_round(1000, 1'b1);
    check("wd_ram_req_low", 32'(ram_req), 32'd0);
    pend[0] = '{1'b1, 1'b1, 16'h0606, 16'hCAFE};
    do_round(1000, 1'b1);
    check("wd_write_not_done", 32'(ram_rd(16'h0606)), 32'(init_val(16'h0606)));
`endif

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p].v && $urandom_range(0, 2) != 0) pend[p] = rand_txn();
      if (!pend[0].v && !pend[1].v) pend[$urandom_range(0, 1)] = rand_txn();
      do_round($urandom_range(0, 3), 1'b0);
    end
    if (pend[0].v || pend[1].v) do_round(0, 1'b0);
    if (pend[0].v || pend[1].v) do_round(0, 1'b0);

    // Reset in the middle of a BUSY access
    pend[1] = '{1'b1, 1'b0, 16'h0303, 16'h0000};
    ram_wait = 1000;
    drive();
    void'(predict(1'b0));
    repeat (2) @(negedge clk);
    check("busy_ram_req", 32'(ram_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_ram_req", 32'(ram_req), 32'd0);
    check("midrst_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
    check("midrst_rdata", {m0_rdata, m1_rdata}, 32'd0);
    exp_q.delete();
    pend[0].v  = 1'b0;
    pend[1].v  = 1'b0;
    drive();
    m_last     = 1'b1;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    repeat (2) @(negedge clk);
    check("midrst_no_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Continuous contention: strict alternation starting with port 0
    grant_log.delete();
    pend[0] = rand_txn();
    pend[1] = rand_txn();
    for (int i = 0; i < 6; i++) begin
      do_round($urandom_range(0, 2), 1'b0);
      for (int p = 0; p < 2; p++) if (!pend[p].v) pend[p] = rand_txn();
    end
    pend[0].v = 1'b0;
    pend[1].v = 1'b0;
    drive();
    check("contention_count", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < grant_log.size(); i++)
      check("contention_order", 32'(grant_log[i]), 32'(i % 2));

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
